// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder/subtractor: operation select,
// result flag bundle and the chunk-width helper.
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// One registered pipeline stage: CW-bit ripple adder followed by an enable-gated
// output register holding the chunk sum, carry out and carry into the chunk MSB.
module adder_chunk #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] sum,
   output logic          cout,
   output logic          cmsb
);

   logic [CW:0]   carry;
   logic [CW-1:0] sum_comb;

   assign carry[0] = cin;

   for (genvar i = 0; i < CW; i++) begin : g_bit
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry[i]),
         .s  (sum_comb[i]),
         .co (carry[i+1])
      );
   end

   // cmsb is the carry into the top bit; only the last stage's copy feeds overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
         cmsb <= 1'b0;
      end else if (en) begin
         sum  <= sum_comb;
         cout <= carry[CW];
         cmsb <= carry[CW-1];
      end
   end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple inside each pipeline chunk is built from these.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor: WIDTH split into STAGES chunks, carry registered
// between stages. Build with ADDER_PIPE_SAT_EN for signed saturation of the result.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  op_e              in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int CW = chunk_width(WIDTH, STAGES);

   if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   // Handshake: a beat moves on valid && ready at either end; a stalled output
   // freezes every stage so the pipe never drops or duplicates a beat.
   logic stall;
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;

   logic [WIDTH-1:0] b_cond;
   logic             c0;

   always_comb begin
      b_cond = in_b;
      c0     = in_cin;
      if (in_op == OP_SUB) begin
         b_cond = ~in_b;
         c0     = 1'b1;
      end
   end

   logic             v_s    [STAGES];
   logic [WIDTH-1:0] a_s    [STAGES];
   logic [WIDTH-1:0] b_s    [STAGES];
   logic [WIDTH-1:0] full_s [STAGES];
   logic             cout_s [STAGES];
   logic             cmsb_s [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             v_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic             c_in;
      logic             v_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic [CW-1:0]    chunk_sum;
      logic [WIDTH-1:0] full;

      if (k == 0) begin : g_first
         assign v_in = in_valid;
         assign a_in = in_a;
         assign b_in = b_cond;
         assign s_in = '0;
         assign c_in = c0;
      end else begin : g_next
         assign v_in = v_s[k-1];
         assign a_in = a_s[k-1];
         assign b_in = b_s[k-1];
         assign s_in = full_s[k-1];
         assign c_in = cout_s[k-1];
      end

      // Operands ride along (skew) and finished chunks ride along (de-skew)
      // so that the whole result word lines up at the last stage.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
         end else if (!stall) begin
            v_q <= v_in;
            a_q <= a_in;
            b_q <= b_in;
            s_q <= s_in;
         end
      end

      adder_chunk #(
         .CW (CW)
      ) u_chunk (
         .clk  (clk),
         .rst  (rst),
         .en   (!stall),
         .a    (a_in[k*CW +: CW]),
         .b    (b_in[k*CW +: CW]),
         .cin  (c_in),
         .sum  (chunk_sum),
         .cout (cout_s[k]),
         .cmsb (cmsb_s[k])
      );

      always_comb begin
         full              = s_q;
         full[k*CW +: CW]  = chunk_sum;
      end

      assign v_s[k]    = v_q;
      assign a_s[k]    = a_q;
      assign b_s[k]    = b_q;
      assign full_s[k] = full;
   end

   logic [WIDTH-1:0] sum_fin;
   flags_t           flags;

   always_comb begin
      sum_fin    = full_s[STAGES-1];
      flags.cout = cout_s[STAGES-1];
      flags.ovf  = cmsb_s[STAGES-1] ^ cout_s[STAGES-1];
`ifdef ADDER_PIPE_SAT_EN
      // On overflow both operand MSBs agree, so A's MSB gives the direction.
      if (flags.ovf) begin
         sum_fin = a_s[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      flags.zero = v_s[STAGES-1] && (sum_fin == '0);
   end

   assign out_valid = v_s[STAGES-1];
   assign out_sum   = sum_fin;
   assign out_cout  = flags.cout;
   assign out_ovf   = flags.ovf;
   assign out_zero  = flags.zero;

endmodule
